// File: rtl/count_demodulator.sv
// ============================================================================
// Module      : count_demodulator
// Description : Loop-back decoder for the counter/modulator glyph stream;
//               decodes, tracks the +1 sequence and counts errored samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_demodulator #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             fib_in,
  input  logic             valid_in,
  output logic [3:0]       value_out,
  output logic             value_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             fib_err,
  output logic             glyph_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int c_cnt_w = $clog2(LOCK_COUNT + 1);
  localparam logic [c_cnt_w-1:0] c_lock_count = c_cnt_w'(LOCK_COUNT);
  localparam logic [ERR_W-1:0]   c_err_max    = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_cnt_w-1:0] r_good_cnt, w_good_next, w_good_inc;
  logic [3:0]         r_prev, w_prev_next, w_expected;
  logic [3:0]         r_value, w_value_next;
  logic               r_value_valid, w_value_valid_next;
  logic               r_locked, w_locked_next;
  logic               r_seq_err, w_seq_err_next;
  logic               r_fib_err, w_fib_err_next;
  logic               r_glyph_err, w_glyph_err_next;
  logic [ERR_W-1:0]   r_err_count, w_err_count_next;
  logic               w_legal, w_fib;
  logic [3:0]         w_dec;

  // Active-low glyph decode; anything outside the 16 hex shapes is illegal
  always_comb begin
    w_legal = 1'b1;
    w_dec   = 4'h0;
    case (seg_in)
      7'b1000000: w_dec = 4'h0;
      7'b1111001: w_dec = 4'h1;
      7'b0100100: w_dec = 4'h2;
      7'b0110000: w_dec = 4'h3;
      7'b0011001: w_dec = 4'h4;
      7'b0010010: w_dec = 4'h5;
      7'b0000010: w_dec = 4'h6;
      7'b1111000: w_dec = 4'h7;
      7'b0000000: w_dec = 4'h8;
      7'b0010000: w_dec = 4'h9;
      7'b0001000: w_dec = 4'hA;
      7'b0000011: w_dec = 4'hB;
      7'b1000110: w_dec = 4'hC;
      7'b0100001: w_dec = 4'hD;
      7'b0000110: w_dec = 4'hE;
      7'b0001110: w_dec = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (w_dec)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13: w_fib = 1'b1;
      default:                                   w_fib = 1'b0;
    endcase
  end

  assign w_expected = r_prev + 4'd1;
  assign w_good_inc = r_good_cnt + c_cnt_w'(1);

  always_comb begin
    w_state_next       = r_state;
    w_good_next        = r_good_cnt;
    w_prev_next        = r_prev;
    w_value_next       = r_value;
    w_value_valid_next = 1'b0;
    w_locked_next      = r_locked;
    w_seq_err_next     = 1'b0;
    w_fib_err_next     = 1'b0;
    w_glyph_err_next   = 1'b0;
    if (valid_in) begin
      if (!w_legal) begin
        w_glyph_err_next = 1'b1;
        w_locked_next    = 1'b0;
        w_good_next      = '0;
        w_state_next     = ST_HUNT;
      end else begin
        w_value_next       = w_dec;
        w_value_valid_next = 1'b1;
        w_fib_err_next     = (fib_in != w_fib);
        w_prev_next        = w_dec;
        case (r_state)
          ST_HUNT: begin
            w_good_next  = c_cnt_w'(1);
            w_state_next = ST_LOCK;
          end
          ST_LOCK: begin
            // Out-of-sequence while acquiring just restarts the run, silently
            if (w_dec == w_expected) begin
              w_good_next = w_good_inc;
              if (w_good_inc == c_lock_count) begin
                w_state_next  = ST_TRACK;
                w_locked_next = 1'b1;
              end
            end else begin
              w_good_next = c_cnt_w'(1);
            end
          end
          ST_TRACK: begin
            if (w_dec != w_expected) begin
              w_seq_err_next = 1'b1;
              w_locked_next  = 1'b0;
              w_good_next    = c_cnt_w'(1);
              w_state_next   = ST_LOCK;
            end
          end
          default: begin
            w_good_next  = '0;
            w_state_next = ST_HUNT;
          end
        endcase
      end
    end
  end

  // One increment per errored sample, however many flags it raised
  always_comb begin
    w_err_count_next = r_err_count;
    if ((w_seq_err_next || w_fib_err_next || w_glyph_err_next) &&
        (r_err_count != c_err_max))
      w_err_count_next = r_err_count + ERR_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_good_cnt    <= '0;
      r_prev        <= 4'd0;
      r_value       <= 4'd0;
      r_value_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_seq_err     <= 1'b0;
      r_fib_err     <= 1'b0;
      r_glyph_err   <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_good_cnt    <= w_good_next;
      r_prev        <= w_prev_next;
      r_value       <= w_value_next;
      r_value_valid <= w_value_valid_next;
      r_locked      <= w_locked_next;
      r_seq_err     <= w_seq_err_next;
      r_fib_err     <= w_fib_err_next;
      r_glyph_err   <= w_glyph_err_next;
      r_err_count   <= w_err_count_next;
    end
  end

  assign value_out   = r_value;
  assign value_valid = r_value_valid;
  assign locked      = r_locked;
  assign seq_err     = r_seq_err;
  assign fib_err     = r_fib_err;
  assign glyph_err   = r_glyph_err;
  assign err_count   = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_count_demodulator.sv
// ============================================================================
// Module      : tb_count_demodulator
// Description : Directed self-checking bench for count_demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_demodulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rst2  = 1'b1;
  logic [6:0] seg_in = 7'b1111111;
  logic       fib_in = 1'b0;
  logic       valid_in = 1'b0;

  logic [3:0] value_out, value_out2;
  logic       value_valid, locked, seq_err, fib_err, glyph_err;
  logic       value_valid2, locked2, seq_err2, fib_err2, glyph_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  count_demodulator #(.LOCK_COUNT(3), .ERR_W(8)) dut (
    .clock(clock), .reset(reset), .seg_in(seg_in), .fib_in(fib_in),
    .valid_in(valid_in), .value_out(value_out), .value_valid(value_valid),
    .locked(locked), .seq_err(seq_err), .fib_err(fib_err),
    .glyph_err(glyph_err), .err_count(err_count)
  );

  count_demodulator #(.LOCK_COUNT(3), .ERR_W(2)) dut_sat (
    .clock(clock), .reset(rst2), .seg_in(seg_in), .fib_in(fib_in),
    .valid_in(valid_in), .value_out(value_out2), .value_valid(value_valid2),
    .locked(locked2), .seq_err(seq_err2), .fib_err(fib_err2),
    .glyph_err(glyph_err2), .err_count(err_count2)
  );

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
      10: glyph = 7'b0001000; 11: glyph = 7'b0000011;
      12: glyph = 7'b1000110; 13: glyph = 7'b0100001;
      14: glyph = 7'b0000110; default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic fib_of(input int v);
    fib_of = (v == 0 || v == 1 || v == 2 || v == 3 || v == 5 || v == 8 || v == 13);
  endfunction

  task automatic drive(input logic [6:0] seg, input logic fib, input logic vld);
    @(negedge clock);
    seg_in = seg; fib_in = fib; valid_in = vld;
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input int v);
    drive(glyph(v), fib_of(v), 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({value_out, value_valid, locked, seq_err, fib_err, glyph_err, err_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: value=%0d vv=%b lk=%b se=%b fe=%b ge=%b cnt=%0d, required all 0",
               value_out, value_valid, locked, seq_err, fib_err, glyph_err, err_count);
    end
    reset = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_stream;
    for (int i = 0; i < 18; i++) begin
      feed(i % 16);
      checks++;
      if (value_out !== 4'(i % 16) || value_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_value[%0d]: value=%0d vv=%b, required %0d vv=1", i, value_out, value_valid, i % 16);
      end
      checks++;
      if (locked !== (i >= 2) || {seq_err, fib_err, glyph_err} !== 3'b000 || err_count !== 8'd0) begin
        errors++;
        $display("FAIL stream_status[%0d]: lk=%b errs=%b cnt=%0d, required lk=%b errs=000 cnt=0",
                 i, locked, {seq_err, fib_err, glyph_err}, err_count, i >= 2);
      end
    end
  endtask

  task automatic test_pause;
    for (int v = 2; v <= 7; v++) feed(v);
    for (int k = 0; k < 5; k++) begin
      drive(glyph(0), 1'b1, 1'b0);
      checks++;
      if (value_valid !== 1'b0 || locked !== 1'b1 || value_out !== 4'd7 || {seq_err, fib_err, glyph_err} !== 3'b000) begin
        errors++;
        $display("FAIL pause_gap[%0d]: vv=%b lk=%b value=%0d errs=%b, required vv=0 lk=1 value=7 errs=000",
                 k, value_valid, locked, value_out, {seq_err, fib_err, glyph_err});
      end
    end
    for (int v = 8; v <= 9; v++) begin
      feed(v);
      checks++;
      if (value_out !== 4'(v) || value_valid !== 1'b1 || locked !== 1'b1 || seq_err !== 1'b0 || err_count !== 8'd0) begin
        errors++;
        $display("FAIL pause_resume[%0d]: value=%0d vv=%b lk=%b se=%b cnt=%0d, required value=%0d vv=1 lk=1 se=0 cnt=0",
                 v, value_out, value_valid, locked, seq_err, err_count, v);
      end
    end
  endtask

  task automatic test_seq_err;
    for (int i = 10; i <= 22; i++) feed(i % 16);
    feed(9);
    checks++;
    if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || value_out !== 4'd9) begin
      errors++;
      $display("FAIL seq_break: se=%b lk=%b cnt=%0d value=%0d, required se=1 lk=0 cnt=1 value=9",
               seq_err, locked, err_count, value_out);
    end
    feed(10);
    checks++;
    if (seq_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL seq_relock_mid: se=%b lk=%b, required se=0 lk=0", seq_err, locked);
    end
    feed(11);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_relock: lk=%b cnt=%0d, required lk=1 cnt=1", locked, err_count);
    end
  endtask

  task automatic test_fib_err;
    for (int i = 12; i <= 19; i++) feed(i % 16);
    drive(glyph(4), 1'b1, 1'b1);
    checks++;
    if (fib_err !== 1'b1 || seq_err !== 1'b0 || locked !== 1'b1 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL fib_mismatch: fe=%b se=%b lk=%b cnt=%0d, required fe=1 se=0 lk=1 cnt=2",
               fib_err, seq_err, locked, err_count);
    end
    feed(5);
    checks++;
    if (fib_err !== 1'b0 || err_count !== 8'd2) begin
      errors++;
      $display("FAIL fib_clear: fe=%b cnt=%0d, required fe=0 cnt=2", fib_err, err_count);
    end
  endtask

  task automatic test_glyph_err;
    drive(7'b1111111, 1'b0, 1'b1);
    checks++;
    if (glyph_err !== 1'b1 || value_valid !== 1'b0 || value_out !== 4'd5 ||
        locked !== 1'b0 || fib_err !== 1'b0 || err_count !== 8'd3) begin
      errors++;
      $display("FAIL glyph_illegal: ge=%b vv=%b value=%0d lk=%b fe=%b cnt=%0d, required ge=1 vv=0 value=5 lk=0 fe=0 cnt=3",
               glyph_err, value_valid, value_out, locked, fib_err, err_count);
    end
    feed(6);
    feed(7);
    checks++;
    if (locked !== 1'b0 || glyph_err !== 1'b0) begin
      errors++;
      $display("FAIL glyph_relock_mid: lk=%b ge=%b, required lk=0 ge=0", locked, glyph_err);
    end
    feed(8);
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd3) begin
      errors++;
      $display("FAIL glyph_relock: lk=%b cnt=%0d, required lk=1 cnt=3", locked, err_count);
    end
  endtask

  task automatic test_multi_err;
    drive(glyph(12), 1'b1, 1'b1);
    checks++;
    if (seq_err !== 1'b1 || fib_err !== 1'b1 || err_count !== 8'd4 || locked !== 1'b0) begin
      errors++;
      $display("FAIL multi_err: se=%b fe=%b cnt=%0d lk=%b, required se=1 fe=1 cnt=4 lk=0",
               seq_err, fib_err, err_count, locked);
    end
    feed(13);
    feed(14);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL multi_relock: lk=%b, required lk=1", locked);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clock);
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({value_out, value_valid, locked, seq_err, fib_err, glyph_err, err_count} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: value=%0d vv=%b lk=%b cnt=%0d, required all 0 before next edge",
               value_out, value_valid, locked, err_count);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_saturate;
    logic [6:0] bad [5];
    bad[0] = 7'b1111111; bad[1] = 7'b0101010; bad[2] = 7'b1111110;
    bad[3] = 7'b0111111; bad[4] = 7'b1010101;
    @(negedge clock);
    rst2 = 1'b1;
    @(negedge clock);
    rst2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(bad[k], 1'b0, 1'b1);
      checks++;
      if (err_count2 !== 2'((k + 1 > 3) ? 3 : k + 1) || glyph_err2 !== 1'b1) begin
        errors++;
        $display("FAIL saturate[%0d]: cnt=%0d ge=%b, required cnt=%0d ge=1",
                 k, err_count2, glyph_err2, (k + 1 > 3) ? 3 : k + 1);
      end
    end
    checks++;
    if (err_count !== 8'd5) begin
      errors++;
      $display("FAIL wide_count: cnt=%0d, required 5", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_pause();
    test_seq_err();
    test_fib_err();
    test_glyph_err();
    test_multi_err();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
